// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT plus a direct-mapped BTB.
// Lookups are combinational from the registered tables. Resolved-branch updates
// train both tables and maintain saturating resolve/mispredict statistics.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lookup_pc,
  output logic             pred_taken,
  output logic             pred_hit,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Prediction tables
  logic [1:0]       bht_q        [DEPTH];
  logic             btb_valid_q  [DEPTH];
  logic [TAG_W-1:0] btb_tag_q    [DEPTH];
  logic [31:0]      btb_target_q [DEPTH];

  // Statistics and mispredict flag
  logic             mispredict_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mis_count_q;

  // Index/tag slices; the byte-offset bits and the PC bits above the tag play no part
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_bits;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[31:IDX_W+TAG_W+2],
                            upd_pc[1:0], upd_pc[31:IDX_W+TAG_W+2]};

  // Lookup: tag-qualified BTB hit, direction from the counter MSB, no bypass of updates
  logic lk_hit;
  assign lk_hit      = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_hit & bht_q[lk_idx][1];
  assign pred_target = lk_hit ? btb_target_q[lk_idx] : 32'h0;

  // Next counter value for the entry being trained (saturating at 00 and 11)
  logic [1:0] bht_cur;
  logic [1:0] bht_d;
  always_comb begin
    bht_cur = bht_q[upd_idx];
    bht_d   = bht_cur;
    if (upd_taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
    end
  end

  // Mispredict: wrong direction, or taken with a wrong target
  logic mis_cond;
  assign mis_cond = (upd_pred_taken != upd_taken) |
                    (upd_taken & (upd_pred_target != upd_target));

  // Table training: counters always move, BTB is (re)allocated only on taken branches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bht_q        <= '{default: 2'b01};
      btb_valid_q  <= '{default: 1'b0};
      btb_tag_q    <= '{default: '0};
      btb_target_q <= '{default: 32'h0};
    end else if (upd_valid) begin
      bht_q[upd_idx] <= bht_d;
      if (upd_taken) begin
        btb_valid_q[upd_idx]  <= 1'b1;
        btb_tag_q[upd_idx]    <= upd_tag;
        btb_target_q[upd_idx] <= upd_target;
      end
    end
  end

  // Statistics: registered one-cycle mispredict pulse and saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_q <= 1'b0;
      br_count_q   <= '0;
      mis_count_q  <= '0;
    end else begin
      mispredict_q <= upd_valid & mis_cond;
      if (upd_valid) begin
        if (br_count_q != '1) br_count_q <= br_count_q + CNT_ONE;
        if (mis_cond && (mis_count_q != '1)) mis_count_q <= mis_count_q + CNT_ONE;
      end
    end
  end

  assign mispredict = mispredict_q;
  assign br_count   = br_count_q;
  assign mis_count  = mis_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural table model checked on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_branch_predictor;
  localparam int IDX_W = 6;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [31:0]      lookup_pc;
  logic             pred_taken, pred_hit;
  logic [31:0]      pred_target;
  logic             upd_valid, upd_taken, upd_pred_taken;
  logic [31:0]      upd_pc, upd_target, upd_pred_target;
  logic             mispredict;
  logic [CNT_W-1:0] br_count, mis_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .br_count(br_count), .mis_count(mis_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_ctr  [DEPTH];
  bit          m_val  [DEPTH];
  int unsigned m_tag  [DEPTH];
  int unsigned m_tgt  [DEPTH];
  bit          m_mis;
  int          m_br, m_misc;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % DEPTH;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * DEPTH)) % (1 << TAG_W);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
      end
      m_mis = 0; m_br = 0; m_misc = 0;
    end else if (upd_valid) begin
      int unsigned k;
      bit wrong;
      k = idx_of(upd_pc);
      wrong = (upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target);
      if (upd_taken) begin
        m_ctr[k] = (m_ctr[k] >= 3) ? 3 : m_ctr[k] + 1;
        m_val[k] = 1; m_tag[k] = tag_of(upd_pc); m_tgt[k] = upd_target;
      end else begin
        m_ctr[k] = (m_ctr[k] <= 0) ? 0 : m_ctr[k] - 1;
      end
      m_mis = wrong;
      if (m_br < CMAX) m_br++;
      if (wrong && m_misc < CMAX) m_misc++;
    end else begin
      m_mis = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT outputs vs model
  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned k;
      bit hit;
      k = idx_of(lookup_pc);
      hit = m_val[k] && (m_tag[k] == tag_of(lookup_pc));
      chk("model pred_hit", {31'b0, pred_hit}, {31'b0, hit});
      chk("model pred_taken", {31'b0, pred_taken}, {31'b0, hit && (m_ctr[k] >= 2)});
      chk("model pred_target", pred_target, hit ? m_tgt[k] : 32'h0);
      chk("model mispredict", {31'b0, mispredict}, {31'b0, m_mis});
      chk("model br_count", 32'(br_count), m_br);
      chk("model mis_count", 32'(mis_count), m_misc);
      $display("cyc pc=%h hit=%0b taken=%0b tgt=%h mis=%0b br=%0d misc=%0d",
               lookup_pc, pred_hit, pred_taken, pred_target, mispredict, br_count, mis_count);
    end
  end

  // One update transaction; returns at posedge+1 with upd_valid dropped
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = ptk; upd_pred_target = ptg;
    @(posedge clk); #1;
    upd_valid = 0;
  endtask

  task automatic chk_pred(input string nm, input logic [31:0] pc, input logic h,
                          input logic t, input logic [31:0] tg);
    lookup_pc = pc; #1;
    chk({nm, " hit"}, {31'b0, pred_hit}, {31'b0, h});
    chk({nm, " taken"}, {31'b0, pred_taken}, {31'b0, t});
    chk({nm, " target"}, pred_target, tg);
  endtask

  initial begin
    rst = 1; lookup_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk_en = 1;

    // 1: reset state
    chk_pred("t1 reset", 32'h100, 0, 0, 32'h0);
    chk("t1 br_count", 32'(br_count), 0);
    chk("t1 mis_count", 32'(mis_count), 0);

    // 2: first taken update, predicted not-taken -> mispredict
    upd(32'h100, 1, 32'h140, 0, 32'h0);
    chk("t2 mispredict", {31'b0, mispredict}, 1);
    chk("t2 mis_count", 32'(mis_count), 1);
    chk_pred("t2 lookup", 32'h100, 1, 1, 32'h140);
    @(posedge clk); #1;
    chk("t2 mispredict clears", {31'b0, mispredict}, 0);

    // 3: saturate at 11, then walk back 10, 01
    for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h140, 1, 32'h140);
    chk("t3 no mispredict", 32'(mis_count), 1);
    upd(32'h100, 0, 32'h0, 1, 32'h140);
    chk_pred("t3 after 1 NT", 32'h100, 1, 1, 32'h140);
    upd(32'h100, 0, 32'h0, 1, 32'h140);
    chk_pred("t3 after 2 NT", 32'h100, 1, 0, 32'h140);
    chk("t3 br_count", 32'(br_count), 7);

    // 4: lookup and update 0x200 in the same cycle (shares index with 0x100)
    lookup_pc = 32'h200;
    upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_target = 32'h280;
    upd_pred_taken = 0; upd_pred_target = 32'h0;
    #1;
    chk("t4 same-cycle old hit", {31'b0, pred_hit}, 0);
    @(posedge clk); #1;
    upd_valid = 0;
    chk_pred("t4 next cycle", 32'h200, 1, 1, 32'h280);

    // 5: alias - retrain 0x100, then 0x200 misses on tag
    upd(32'h100, 1, 32'h140, 1, 32'h140);
    chk_pred("t5 alias", 32'h100 + (4 << IDX_W), 0, 0, 32'h0);
    chk_pred("t5 owner", 32'h103, 1, 1, 32'h140);

    // 6: saturate br_count (9 so far), then reset mid-update
    for (int i = 0; i < 10; i++)
      upd(32'h1000 + 4 * i, i[0], 32'h2000 + 8 * i, 0, 32'h0);
    chk("t6 br_count sat", 32'(br_count), 15);
    upd_valid = 1; upd_pc = 32'h300; upd_taken = 1; upd_target = 32'h340;
    upd_pred_taken = 0; upd_pred_target = 0;
    #2 rst = 0;
    #1;
    chk("t6 rst br_count", 32'(br_count), 0);
    chk("t6 rst mis_count", 32'(mis_count), 0);
    @(posedge clk); #1;
    upd_valid = 0;
    chk("t6 rst mispredict", {31'b0, mispredict}, 0);
    chk_pred("t6 rst 0x300", 32'h300, 0, 0, 32'h0);
    chk_pred("t6 rst 0x100", 32'h100, 0, 0, 32'h0);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
